// File: rtl/ext_bus_pkg.sv
// Shared types and encodings for the multiplexed external bus sequencer.
// Holds the FSM state enum, the pad drive/release patterns and the rw encodings.
package ext_bus_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        WAIT = 3'd2,
        DATA = 3'd3,
        TURN = 3'd4
    } state_t;

    localparam logic [7:0] BUS_DRIVE   = 8'hFF;
    localparam logic [7:0] BUS_RELEASE = 8'h00;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Pad pattern for the WAIT/DATA phases: writes drive wdata, reads float the bus.
    function automatic logic [7:0] data_phase_byte(input logic we, input logic [7:0] wdata);
        return we ? wdata : 8'h00;
    endfunction

    function automatic logic [7:0] data_phase_en(input logic we);
        return we ? BUS_DRIVE : BUS_RELEASE;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the requester that was not granted last wins.
// last_grant only moves when the sequencer strobes i_update while a grant is valid.
module rr_arbiter2
    import ext_bus_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req0,
    input  logic       i_req1,
    input  logic       i_update,
    output logic       o_grant_valid,
    output logic [1:0] o_grant
);

    logic r_last_m1;

    assign o_grant_valid = i_req0 | i_req1;

    always_comb begin
        o_grant = 2'b00;
        if (i_req0 && i_req1) begin
            o_grant = r_last_m1 ? 2'b01 : 2'b10;
        end else if (i_req0) begin
            o_grant = 2'b01;
        end else if (i_req1) begin
            o_grant = 2'b10;
        end
    end

    // Reset to "m1 last" so m0 wins the very first tie.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_m1 <= 1'b1;
        end else if (i_update && o_grant_valid) begin
            r_last_m1 <= o_grant[1];
        end
    end

endmodule

// File: rtl/ext_bus_sequencer.sv
// Sequences ADDR/WAIT/DATA/TURN phases of the shared 8-bit multiplexed bus for two
// requesters; every pad and handshake output comes straight from a register.
module ext_bus_sequencer
    import ext_bus_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       m0_req,
    input  logic       m0_we,
    input  logic [7:0] m0_addr,
    input  logic [7:0] m0_wdata,
    output logic       m0_ack,
    input  logic       m1_req,
    input  logic       m1_we,
    input  logic [7:0] m1_addr,
    input  logic [7:0] m1_wdata,
    output logic       m1_ack,
    output logic [7:0] rdata,
    output logic       err,
    output logic       busy,
    input  logic [7:0] bus_in,
    output logic [7:0] bus_out,
    output logic [7:0] bus_en,
    output logic       ale,
    output logic       rw,
    input  logic       bus_rdy,
    output state_t     dbg_state
);

    localparam int unsigned WAIT_LOAD_I  = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
    localparam logic [3:0]  WAIT_LOAD    = 4'(WAIT_LOAD_I);
    localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t     r_state;
    logic       r_we;
    logic [7:0] r_wdata;
    logic       r_gnt_m1;
    logic [3:0] r_wait_cnt;
    logic [7:0] r_tmo_cnt;
    logic       r_ale;
    logic       r_rw;
    logic [7:0] r_bus_en;
    logic [7:0] r_bus_out;
    logic       r_m0_ack;
    logic       r_m1_ack;
    logic [7:0] r_rdata;
    logic       r_err;
    logic       r_busy;

    logic       w_grant_valid;
    logic [1:0] w_grant;
    logic       w_arb_update;
    logic       w_sel_we;
    logic [7:0] w_sel_addr;
    logic [7:0] w_sel_wdata;

    assign w_arb_update = (r_state == IDLE);

    rr_arbiter2 u_arb (
        .i_clk         (clk),
        .i_rst_n       (rst),
        .i_req0        (m0_req),
        .i_req1        (m1_req),
        .i_update      (w_arb_update),
        .o_grant_valid (w_grant_valid),
        .o_grant       (w_grant)
    );

    assign w_sel_we    = w_grant[1] ? m1_we    : m0_we;
    assign w_sel_addr  = w_grant[1] ? m1_addr  : m0_addr;
    assign w_sel_wdata = w_grant[1] ? m1_wdata : m0_wdata;

    // Outputs are registered one step ahead: each transition loads the pad values
    // that belong to the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_we       <= 1'b0;
            r_wdata    <= 8'h00;
            r_gnt_m1   <= 1'b0;
            r_wait_cnt <= 4'd0;
            r_tmo_cnt  <= 8'd0;
            r_ale      <= 1'b0;
            r_rw       <= RW_READ;
            r_bus_en   <= BUS_RELEASE;
            r_bus_out  <= 8'h00;
            r_m0_ack   <= 1'b0;
            r_m1_ack   <= 1'b0;
            r_rdata    <= 8'h00;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_m0_ack <= 1'b0;
            r_m1_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_gnt_m1  <= w_grant[1];
                        r_we      <= w_sel_we;
                        r_wdata   <= w_sel_wdata;
                        r_ale     <= 1'b1;
                        r_bus_out <= w_sel_addr;
                        r_bus_en  <= BUS_DRIVE;
                        r_rw      <= w_sel_we ? RW_WRITE : RW_READ;
                        r_busy    <= 1'b1;
                        r_state   <= ADDR;
                    end
                end
                ADDR: begin
                    r_ale      <= 1'b0;
                    r_bus_out  <= data_phase_byte(r_we, r_wdata);
                    r_bus_en   <= data_phase_en(r_we);
                    r_wait_cnt <= WAIT_LOAD;
                    r_tmo_cnt  <= 8'd0;
                    r_state    <= (WAIT_CYCLES > 0) ? WAIT : DATA;
                end
                WAIT: begin
                    if (r_wait_cnt == 4'd0) begin
                        r_state <= DATA;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                DATA: begin
                    // A ready in the last allowed cycle still beats the timeout.
                    if (bus_rdy || (r_tmo_cnt == TIMEOUT_LAST)) begin
                        if (bus_rdy) begin
                            if (!r_we) begin
                                r_rdata <= bus_in;
                            end
                            r_err <= 1'b0;
                        end else begin
                            r_rdata <= 8'h00;
                            r_err   <= 1'b1;
                        end
                        r_m0_ack  <= ~r_gnt_m1;
                        r_m1_ack  <= r_gnt_m1;
                        r_bus_en  <= BUS_RELEASE;
                        r_bus_out <= 8'h00;
                        r_ale     <= 1'b0;
                        r_rw      <= RW_READ;
                        r_state   <= TURN;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 8'd1;
                    end
                end
                TURN: begin
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_bus_en <= BUS_RELEASE;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign m0_ack    = r_m0_ack;
    assign m1_ack    = r_m1_ack;
    assign rdata     = r_rdata;
    assign err       = r_err;
    assign busy      = r_busy;
    assign bus_out   = r_bus_out;
    assign bus_en    = r_bus_en;
    assign ale       = r_ale;
    assign rw        = r_rw;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_ext_bus_sequencer.sv
// Bench for ext_bus_sequencer: a WAIT_CYCLES=1/TIMEOUT=4 instance driven from a vector
// table and random transactions, plus a WAIT_CYCLES=0 instance for the short path.
module tb_ext_bus_sequencer;
    import ext_bus_pkg::*;

    localparam int WC  = 1;
    localparam int TMO = 4;

    typedef struct {
        logic       m;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] bin;
        int         lat;
        logic [7:0] exp_rdata;
        logic       exp_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       m0_req, m0_we, m0_ack, m1_req, m1_we, m1_ack;
    logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [7:0] rdata, bus_in, bus_out, bus_en;
    logic       err, busy, ale, rw, bus_rdy;
    state_t     dbg_state;

    logic       z_m0_req, z_m0_we, z_m0_ack, z_m1_req, z_m1_we, z_m1_ack;
    logic [7:0] z_m0_addr, z_m0_wdata, z_m1_addr, z_m1_wdata;
    logic [7:0] z_rdata, z_bus_in, z_bus_out, z_bus_en;
    logic       z_err, z_busy, z_ale, z_rw, z_bus_rdy;
    state_t     z_dbg_state;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [11:0] exp_q[$];
    logic [7:0]  cur_bin  = 8'h00;
    int          cur_lat  = 0;
    vec_t        tbl[8];

    ext_bus_sequencer #(.WAIT_CYCLES(WC), .TIMEOUT(TMO)) u_dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(m1_ack),
        .rdata(rdata), .err(err), .busy(busy), .bus_in(bus_in), .bus_out(bus_out),
        .bus_en(bus_en), .ale(ale), .rw(rw), .bus_rdy(bus_rdy), .dbg_state(dbg_state)
    );

    ext_bus_sequencer #(.WAIT_CYCLES(0), .TIMEOUT(16)) u_dut0 (
        .clk(clk), .rst(rst),
        .m0_req(z_m0_req), .m0_we(z_m0_we), .m0_addr(z_m0_addr), .m0_wdata(z_m0_wdata), .m0_ack(z_m0_ack),
        .m1_req(z_m1_req), .m1_we(z_m1_we), .m1_addr(z_m1_addr), .m1_wdata(z_m1_wdata), .m1_ack(z_m1_ack),
        .rdata(z_rdata), .err(z_err), .busy(z_busy), .bus_in(z_bus_in), .bus_out(z_bus_out),
        .bus_en(z_bus_en), .ale(z_ale), .rw(z_rw), .bus_rdy(z_bus_rdy), .dbg_state(z_dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic set_req(input logic m, input logic req, input logic we,
                           input logic [7:0] addr, input logic [7:0] wdata);
        if (m) begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end
    endtask

    task automatic drop_req(input logic m);
        set_req(m, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    endtask

    // Entered at a falling edge with the DUT in IDLE; leaves at the IDLE edge after TURN.
    task automatic run_vec(input string tag, input vec_t v);
        int         ndata;
        logic [7:0] dexp_out, dexp_en;
        logic       exp_rw;
        set_req(v.m, 1'b1, v.we, v.addr, v.wdata);
        cur_bin  = v.bin;
        cur_lat  = v.lat;
        exp_q.push_back({~v.we, v.m, ~v.m, (v.we ? 8'h00 : v.exp_rdata), v.exp_err});
        ndata    = (v.lat < TMO) ? v.lat + 1 : TMO;
        dexp_out = v.we ? v.wdata : 8'h00;
        dexp_en  = v.we ? 8'hFF : 8'h00;
        exp_rw   = ~v.we;
        @(negedge clk);
        check({tag, "_addr_ale"}, ale, 1'b1);
        check({tag, "_addr_bus"}, bus_out, v.addr);
        check({tag, "_addr_en"}, bus_en, 8'hFF);
        check({tag, "_addr_rw"}, rw, exp_rw);
        check({tag, "_addr_busy"}, busy, 1'b1);
        for (int i = 0; i < WC + ndata; i++) begin
            @(negedge clk);
            check({tag, "_data_ale"}, ale, 1'b0);
            check({tag, "_data_bus"}, bus_out, dexp_out);
            check({tag, "_data_en"}, bus_en, dexp_en);
            check({tag, "_data_ack"}, {m1_ack, m0_ack}, 2'b00);
        end
        @(negedge clk);
        check({tag, "_turn_ack"}, {m1_ack, m0_ack}, v.m ? 2'b10 : 2'b01);
        check({tag, "_turn_en"}, bus_en, 8'h00);
        check({tag, "_turn_rw"}, rw, 1'b1);
        check({tag, "_turn_err"}, err, v.exp_err);
        if (!v.we) check({tag, "_turn_rdata"}, rdata, v.exp_rdata);
        drop_req(v.m);
        @(negedge clk);
        check({tag, "_idle_busy"}, busy, 1'b0);
        check({tag, "_idle_err"}, err, 1'b0);
        check({tag, "_idle_ack"}, {m1_ack, m0_ack}, 2'b00);
        check({tag, "_idle_en"}, bus_en, 8'h00);
    endtask

    task automatic wait_ale(output logic [7:0] a, output int cyc);
        a = 8'h00;
        cyc = 0;
        while (cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (ale) begin
                a = bus_out;
                break;
            end
        end
    endtask

    task automatic wait_acks(output logic [1:0] acks);
        acks = 2'b00;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) begin
                acks = {m1_ack, m0_ack};
                break;
            end
        end
    endtask

    // Pad model: presents the vector's byte and ready only during DATA, noise elsewhere.
    initial begin : pad_model
        int dcnt;
        dcnt = 0;
        bus_rdy = 1'b0;
        bus_in = 8'h00;
        forever begin
            @(negedge clk);
            if (dbg_state == DATA) begin
                bus_rdy = (dcnt >= cur_lat);
                bus_in  = cur_bin;
                dcnt++;
            end else begin
                dcnt    = 0;
                bus_rdy = 1'($urandom_range(0, 1));
                bus_in  = 8'($urandom_range(0, 255));
            end
        end
    end

    initial begin : sb_monitor
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (rst && (m0_ack || m1_ack)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected_ack: got m1_ack=%0b m0_ack=%0b expected no ack", m1_ack, m0_ack);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_ack_src", {m1_ack, m0_ack}, e[10:9]);
                    check("sb_err", err, e[0]);
                    if (e[11]) check("sb_rdata", rdata, e[8:1]);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no end of test expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] a;
        logic [1:0] acks;
        int         cyc;
        vec_t       r;

        rst = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        z_m0_req = 1'b0; z_m0_we = 1'b0; z_m0_addr = 8'h00; z_m0_wdata = 8'h00;
        z_m1_req = 1'b0; z_m1_we = 1'b0; z_m1_addr = 8'h00; z_m1_wdata = 8'h00;
        z_bus_rdy = 1'b1;
        z_bus_in  = 8'h6B;

        tbl[0] = '{m:1'b0, we:1'b1, addr:8'h3C, wdata:8'hA5, bin:8'h00, lat:0, exp_rdata:8'h00, exp_err:1'b0};
        tbl[1] = '{m:1'b1, we:1'b0, addr:8'h7E, wdata:8'h00, bin:8'h5A, lat:0, exp_rdata:8'h5A, exp_err:1'b0};
        tbl[2] = '{m:1'b0, we:1'b0, addr:8'h10, wdata:8'h00, bin:8'hC3, lat:2, exp_rdata:8'hC3, exp_err:1'b0};
        tbl[3] = '{m:1'b1, we:1'b1, addr:8'h81, wdata:8'h3F, bin:8'h00, lat:1, exp_rdata:8'h00, exp_err:1'b0};
        tbl[4] = '{m:1'b0, we:1'b0, addr:8'hFF, wdata:8'h00, bin:8'h96, lat:3, exp_rdata:8'h96, exp_err:1'b0};
        tbl[5] = '{m:1'b1, we:1'b0, addr:8'h00, wdata:8'h00, bin:8'h77, lat:4, exp_rdata:8'h00, exp_err:1'b1};
        tbl[6] = '{m:1'b0, we:1'b1, addr:8'h55, wdata:8'hAA, bin:8'h00, lat:9, exp_rdata:8'h00, exp_err:1'b1};
        tbl[7] = '{m:1'b0, we:1'b0, addr:8'h24, wdata:8'h00, bin:8'hE1, lat:0, exp_rdata:8'hE1, exp_err:1'b0};

        repeat (2) @(negedge clk);
        check("rst_ale", ale, 1'b0);
        check("rst_rw", rw, 1'b1);
        check("rst_en", bus_en, 8'h00);
        check("rst_bus_out", bus_out, 8'h00);
        check("rst_acks", {m1_ack, m0_ack}, 2'b00);
        check("rst_rdata", rdata, 8'h00);
        check("rst_err", err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_z_rw", z_rw, 1'b1);
        check("rst_z_en", z_bus_en, 8'h00);
        rst = 1'b1;

        // Simultaneous requests: m0 first from reset, then m1, and the same again.
        for (int rnd = 0; rnd < 2; rnd++) begin
            cur_lat = 0;
            cur_bin = 8'(8'hC4 + rnd);
            set_req(1'b0, 1'b1, 1'b0, 8'h11, 8'h00);
            set_req(1'b1, 1'b1, 1'b0, 8'h22, 8'h00);
            exp_q.push_back({1'b1, 2'b01, cur_bin, 1'b0});
            exp_q.push_back({1'b1, 2'b10, cur_bin, 1'b0});
            wait_ale(a, cyc);
            check("tie_first_addr", a, 8'h11);
            check("tie_first_lat", cyc, 1);
            wait_acks(acks);
            check("tie_first_ack", acks, 2'b01);
            drop_req(1'b0);
            wait_ale(a, cyc);
            check("tie_second_addr", a, 8'h22);
            check("tie_gap", cyc, 2);
            wait_acks(acks);
            check("tie_second_ack", acks, 2'b10);
            drop_req(1'b1);
            @(negedge clk);
        end

        for (int i = 0; i < 8; i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i]);
        end

        for (int k = 0; k < 20; k++) begin
            r.m         = 1'($urandom_range(0, 1));
            r.we        = 1'($urandom_range(0, 1));
            r.addr      = 8'($urandom_range(0, 255));
            r.wdata     = 8'($urandom_range(0, 255));
            r.bin       = 8'($urandom_range(0, 255));
            r.lat       = int'($urandom_range(0, 6));
            r.exp_err   = (r.lat >= TMO);
            r.exp_rdata = r.exp_err ? 8'h00 : r.bin;
            run_vec($sformatf("rnd%0d", k), r);
        end

        // Asynchronous reset in the middle of WAIT.
        cur_lat = 0;
        set_req(1'b0, 1'b1, 1'b1, 8'h5C, 8'h33);
        @(negedge clk);
        check("rstw_addr_ale", ale, 1'b1);
        @(negedge clk);
        check("rstw_in_wait", dbg_state, WAIT);
        check("rstw_wait_en", bus_en, 8'hFF);
        #2 rst = 1'b0;
        #1;
        check("rstw_en", bus_en, 8'h00);
        check("rstw_ale", ale, 1'b0);
        check("rstw_busy", busy, 1'b0);
        check("rstw_rw", rw, 1'b1);
        check("rstw_acks", {m1_ack, m0_ack}, 2'b00);
        drop_req(1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstw_after_busy", busy, 1'b0);
        run_vec("post_rst", '{m:1'b1, we:1'b0, addr:8'h5C, wdata:8'h00, bin:8'h39, lat:1,
                              exp_rdata:8'h39, exp_err:1'b0});

        // WAIT_CYCLES=0 instance: ADDR straight to DATA, req dropped after grant.
        z_m0_req = 1'b1; z_m0_we = 1'b0; z_m0_addr = 8'h44;
        @(negedge clk);
        check("z_addr_ale", z_ale, 1'b1);
        check("z_addr_bus", z_bus_out, 8'h44);
        check("z_addr_rw", z_rw, 1'b1);
        z_m0_req = 1'b0;
        @(negedge clk);
        check("z_data_state", z_dbg_state, DATA);
        check("z_data_en", z_bus_en, 8'h00);
        check("z_data_ack", {z_m1_ack, z_m0_ack}, 2'b00);
        @(negedge clk);
        check("z_turn_ack", {z_m1_ack, z_m0_ack}, 2'b01);
        check("z_turn_rdata", z_rdata, 8'h6B);
        check("z_turn_err", z_err, 1'b0);
        @(negedge clk);
        check("z_idle_ack", z_m0_ack, 1'b0);
        check("z_idle_busy", z_busy, 1'b0);
        z_m1_req = 1'b1; z_m1_we = 1'b1; z_m1_addr = 8'h9A; z_m1_wdata = 8'h5E;
        @(negedge clk);
        check("z_w_addr_bus", z_bus_out, 8'h9A);
        check("z_w_addr_rw", z_rw, 1'b0);
        z_m1_we = 1'b1; z_m1_wdata = 8'h00; z_m1_addr = 8'h00;
        @(negedge clk);
        check("z_w_data_bus", z_bus_out, 8'h5E);
        check("z_w_data_en", z_bus_en, 8'hFF);
        @(negedge clk);
        check("z_w_turn_ack", {z_m1_ack, z_m0_ack}, 2'b10);
        check("z_w_turn_en", z_bus_en, 8'h00);
        z_m1_req = 1'b0;
        @(negedge clk);

        check("sb_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
